branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/bru_pkg.sv | 13 +
 rtl/bru_fifo.sv | 57 +++++
 rtl/branch_resolve_unit.sv | 96 +++++++++
 tb/tb_branch_resolve_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
package bru_pkg;

  localparam int unsigned PC_W          = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] pc_imm;
    logic [PC_W-1:0] pc_add_4;
  } bru_entry_t;

endpackage

// File: rtl/bru_fifo.sv
// In-flight prediction FIFO: power-of-two ring with occupancy counter and synchronous clear.
module bru_fifo
  import bru_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  bru_entry_t wr_data,
  output bru_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  bru_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    do_pop  = pop & ~empty;
    // At full, a push is accepted only when the head slot is freed in the same cycle
    do_push = push & (~full | do_pop);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches IF-stage predictions against ID-stage resolutions; flushes on mispredict.
// Optional performance counters enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pred_valid,
  input  logic            pred_taken,
  input  logic [PC_W-1:0] pred_pc_imm,
  input  logic [PC_W-1:0] pred_pc_add_4,
  input  logic            res_valid,
  input  logic            res_taken,
  input  logic            stall,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic            upd_valid,
  output logic            upd_taken,
  output logic            fifo_full,
  output logic            fifo_empty,
  output logic            err_overflow,
  output logic            err_underflow
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_mispredict
`endif
);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W == 0) begin : g_param_check
    $error("branch_resolve_unit: DEPTH must be a power of 2 in 2..16 and CNT_W nonzero");
  end

  bru_entry_t head;
  bru_entry_t wr_data;
  logic       res_fire;
  logic       push;
  logic       pop;
  logic       mispredict;

  always_comb begin
    res_fire    = res_valid & ~stall;
    pop         = res_fire & ~fifo_empty;
    mispredict  = pop & (head.taken != res_taken);
    flush       = mispredict;
    redirect_pc = '0;
    // Redirect to the path the prediction did not take
    if (mispredict) redirect_pc = head.taken ? head.pc_add_4 : head.pc_imm;
    push        = pred_valid & ~stall & ~mispredict;
    wr_data     = '{taken: pred_taken, pc_imm: pred_pc_imm, pc_add_4: pred_pc_add_4};
  end

  bru_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .clear   (mispredict),
    .wr_data (wr_data),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid     <= 1'b0;
      upd_taken     <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      upd_valid     <= pop;
      upd_taken     <= pop & res_taken;
      err_overflow  <= err_overflow | (push & fifo_full & ~pop);
      err_underflow <= err_underflow | (res_fire & fifo_empty);
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_branch     <= '0;
      cnt_mispredict <= '0;
    end else begin
      if (pop && cnt_branch != '1)            cnt_branch     <= cnt_branch + CNT_W'(1);
      if (mispredict && cnt_mispredict != '1) cnt_mispredict <= cnt_mispredict + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random traffic vs a queue model.
module tb_branch_resolve_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_taken, res_valid, res_taken, stall;
  logic [31:0] pred_pc_imm, pred_pc_add_4;
  logic        flush, upd_valid, upd_taken, fifo_full, fifo_empty, err_overflow, err_underflow;
  logic [31:0] redirect_pc;
`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_branch, cnt_mispredict;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .pred_pc_imm   (pred_pc_imm),
    .pred_pc_add_4 (pred_pc_add_4),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .stall         (stall),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .upd_valid     (upd_valid),
    .upd_taken     (upd_taken),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
`ifdef BRU_PERF_CNT_EN
    ,
    .cnt_branch     (cnt_branch),
    .cnt_mispredict (cnt_mispredict)
`endif
  );

  typedef struct {
    bit        taken;
    bit [31:0] imm;
    bit [31:0] add4;
  } ent_t;

  ent_t        m_q[$];
  bit          m_ovf, m_unf, m_upd_valid, m_upd_taken;
  int unsigned m_cnt_br, m_cnt_mp;
  bit          e_flush;
  bit [31:0]   e_redirect;
  logic        s_flush;
  logic [31:0] s_redirect;
  int unsigned nvec = 0;
  int unsigned nerr = 0;

  task automatic model_clear();
    m_q.delete();
    m_ovf = 0; m_unf = 0; m_upd_valid = 0; m_upd_taken = 0;
    m_cnt_br = 0; m_cnt_mp = 0;
    e_flush = 0; e_redirect = '0;
  endtask

  task automatic drive_idle();
    pred_valid = 0; pred_taken = 0; pred_pc_imm = '0; pred_pc_add_4 = '0;
    res_valid = 0; res_taken = 0; stall = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // One clock: drive inputs, sample combinational outputs mid-cycle, advance the model at the edge.
  task automatic step(input bit pv, input bit pt, input bit [31:0] imm, input bit [31:0] add4,
                      input bit rv, input bit rt, input bit st);
    bit   popped;
    ent_t e;
    pred_valid = pv; pred_taken = pt; pred_pc_imm = imm; pred_pc_add_4 = add4;
    res_valid = rv; res_taken = rt; stall = st;
    @(negedge clk);
    s_flush = flush;
    s_redirect = redirect_pc;
    e_flush = 0;
    e_redirect = '0;
    popped = !st && rv && m_q.size() > 0;
    if (popped && m_q[0].taken != rt) begin
      e_flush = 1;
      e_redirect = m_q[0].taken ? m_q[0].add4 : m_q[0].imm;
    end
    @(posedge clk);
    if (!st && rv && m_q.size() == 0) m_unf = 1;
    if (e_flush) m_q.delete();
    else begin
      if (popped) void'(m_q.pop_front());
      if (pv && !st) begin
        if (m_q.size() < DEPTH) begin
          e.taken = pt; e.imm = imm; e.add4 = add4;
          m_q.push_back(e);
        end else m_ovf = 1;
      end
    end
    m_upd_valid = popped;
    m_upd_taken = popped && rt;
    if (popped && m_cnt_br < (1 << CNT_W) - 1) m_cnt_br++;
    if (e_flush && m_cnt_mp < (1 << CNT_W) - 1) m_cnt_mp++;
    #1;
    drive_idle();
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (fifo_empty !== 1'b1) begin nerr++; $display("FAIL reset_empty: got %0b want 1", fifo_empty); end
    nvec++; if (fifo_full !== 1'b0) begin nerr++; $display("FAIL reset_full: got %0b want 0", fifo_full); end
    nvec++; if (flush !== 1'b0) begin nerr++; $display("FAIL reset_flush: got %0b want 0", flush); end
    nvec++; if (redirect_pc !== 32'h0) begin nerr++; $display("FAIL reset_redirect: got %h want 0", redirect_pc); end
    nvec++; if (upd_valid !== 1'b0) begin nerr++; $display("FAIL reset_upd_valid: got %0b want 0", upd_valid); end
    nvec++; if (upd_taken !== 1'b0) begin nerr++; $display("FAIL reset_upd_taken: got %0b want 0", upd_taken); end
    nvec++; if (err_overflow !== 1'b0) begin nerr++; $display("FAIL reset_ovf: got %0b want 0", err_overflow); end
    nvec++; if (err_underflow !== 1'b0) begin nerr++; $display("FAIL reset_unf: got %0b want 0", err_underflow); end
`ifdef BRU_PERF_CNT_EN
    nvec++; if (cnt_branch !== '0) begin nerr++; $display("FAIL reset_cnt_branch: got %0d want 0", cnt_branch); end
    nvec++; if (cnt_mispredict !== '0) begin nerr++; $display("FAIL reset_cnt_mp: got %0d want 0", cnt_mispredict); end
`endif
    step(1, 1, 32'h40, 32'h44, 0, 0, 0);
    step(1, 0, 32'h50, 32'h54, 0, 0, 0);
    nvec++; if (fifo_empty !== 1'b0) begin nerr++; $display("FAIL prefill_empty: got %0b want 0", fifo_empty); end
    rst = 1'b1;
    #2;
    nvec++; if (fifo_empty !== 1'b1) begin nerr++; $display("FAIL async_rst_empty: got %0b want 1", fifo_empty); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_correct_predict();
    do_reset();
    step(1, 1, 32'h100, 32'h08, 0, 0, 0);
    step(0, 0, 32'h0, 32'h0, 1, 1, 0);
    nvec++; if (s_flush !== 1'b0) begin nerr++; $display("FAIL ok_flush: got %0b want 0", s_flush); end
    nvec++; if (s_redirect !== 32'h0) begin nerr++; $display("FAIL ok_redirect: got %h want 0", s_redirect); end
    nvec++; if (upd_valid !== 1'b1) begin nerr++; $display("FAIL ok_upd_valid: got %0b want 1", upd_valid); end
    nvec++; if (upd_taken !== 1'b1) begin nerr++; $display("FAIL ok_upd_taken: got %0b want 1", upd_taken); end
    nvec++; if (fifo_empty !== 1'b1) begin nerr++; $display("FAIL ok_empty: got %0b want 1", fifo_empty); end
    step(0, 0, 32'h0, 32'h0, 0, 0, 0);
    nvec++; if (upd_valid !== 1'b0) begin nerr++; $display("FAIL ok_upd_pulse: got %0b want 0", upd_valid); end
  endtask

  task automatic test_mispredict();
    do_reset();
    step(1, 1, 32'h100, 32'h08, 0, 0, 0);
    step(0, 0, 32'h0, 32'h0, 1, 0, 0);
    nvec++; if (s_flush !== 1'b1) begin nerr++; $display("FAIL mp_flush: got %0b want 1", s_flush); end
    nvec++; if (s_redirect !== 32'h08) begin nerr++; $display("FAIL mp_redirect: got %h want 00000008", s_redirect); end
    nvec++; if (fifo_empty !== 1'b1) begin nerr++; $display("FAIL mp_empty: got %0b want 1", fifo_empty); end
    nvec++; if (upd_valid !== 1'b1 || upd_taken !== 1'b0) begin nerr++; $display("FAIL mp_upd: got v=%0b t=%0b want v=1 t=0", upd_valid, upd_taken); end
    step(1, 0, 32'h300, 32'h0C, 0, 0, 0);
    step(0, 0, 32'h0, 32'h0, 1, 1, 0);
    nvec++; if (s_flush !== 1'b1 || s_redirect !== 32'h300) begin nerr++; $display("FAIL mp_nt_redirect: got f=%0b pc=%h want f=1 pc=00000300", s_flush, s_redirect); end
  endtask

  task automatic test_overflow();
    bit        tk [4];
    bit [31:0] im [4];
    bit [31:0] ad [4];
    bit [31:0] want;
    tk[0] = 1; tk[1] = 0; tk[2] = 0; tk[3] = 1;
    for (int i = 0; i < 4; i++) begin
      im[i] = $urandom; ad[i] = $urandom;
    end
    do_reset();
    for (int i = 0; i < 4; i++) step(1, tk[i], im[i], ad[i], 0, 0, 0);
    nvec++; if (fifo_full !== 1'b1 || err_overflow !== 1'b0) begin nerr++; $display("FAIL ovf_fill: got full=%0b ovf=%0b want full=1 ovf=0", fifo_full, err_overflow); end
    step(1, 0, 32'hDEAD0000, 32'hDEAD0004, 0, 0, 0);
    nvec++; if (fifo_full !== 1'b1) begin nerr++; $display("FAIL ovf_full: got %0b want 1", fifo_full); end
    nvec++; if (err_overflow !== 1'b1) begin nerr++; $display("FAIL ovf_err: got %0b want 1", err_overflow); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 32'h0, 32'h0, 1, tk[i], 0);
      nvec++; if (s_flush !== 1'b0 || upd_taken !== tk[i]) begin nerr++; $display("FAIL ovf_order%0d: got flush=%0b upd_taken=%0b want flush=0 upd_taken=%0b", i, s_flush, upd_taken, tk[i]); end
    end
    want = tk[3] ? ad[3] : im[3];
    step(0, 0, 32'h0, 32'h0, 1, !tk[3], 0);
    nvec++; if (s_flush !== 1'b1 || s_redirect !== want) begin nerr++; $display("FAIL ovf_last: got f=%0b pc=%h want f=1 pc=%h", s_flush, s_redirect, want); end
    nvec++; if (fifo_empty !== 1'b1 || err_overflow !== 1'b1) begin nerr++; $display("FAIL ovf_sticky: got empty=%0b ovf=%0b want 1 1", fifo_empty, err_overflow); end
  endtask

  task automatic test_full_push_pop();
    bit tk [4];
    tk[0] = 0; tk[1] = 1; tk[2] = 1; tk[3] = 0;
    do_reset();
    for (int i = 0; i < 4; i++) step(1, tk[i], 32'h1000 + 32'(i), 32'h2000 + 32'(i), 0, 0, 0);
    step(1, 1, 32'h5550, 32'h5554, 1, tk[0], 0);
    nvec++; if (s_flush !== 1'b0) begin nerr++; $display("FAIL fpp_flush: got %0b want 0", s_flush); end
    nvec++; if (fifo_full !== 1'b1) begin nerr++; $display("FAIL fpp_full: got %0b want 1", fifo_full); end
    nvec++; if (err_overflow !== 1'b0) begin nerr++; $display("FAIL fpp_ovf: got %0b want 0", err_overflow); end
    for (int i = 1; i < 4; i++) step(0, 0, 32'h0, 32'h0, 1, tk[i], 0);
    nvec++; if (fifo_empty !== 1'b0) begin nerr++; $display("FAIL fpp_one_left: got empty=%0b want 0", fifo_empty); end
    step(0, 0, 32'h0, 32'h0, 1, 0, 0);
    nvec++; if (s_flush !== 1'b1 || s_redirect !== 32'h5554) begin nerr++; $display("FAIL fpp_newest: got f=%0b pc=%h want f=1 pc=00005554", s_flush, s_redirect); end
    nvec++; if (fifo_empty !== 1'b1) begin nerr++; $display("FAIL fpp_drained: got %0b want 1", fifo_empty); end
  endtask

  task automatic test_flush_push();
    do_reset();
    step(1, 1, 32'h100, 32'h08, 0, 0, 0);
    step(1, 0, 32'h200, 32'h204, 1, 0, 0);
    nvec++; if (s_flush !== 1'b1 || s_redirect !== 32'h08) begin nerr++; $display("FAIL fp_flush: got f=%0b pc=%h want f=1 pc=00000008", s_flush, s_redirect); end
    nvec++; if (fifo_empty !== 1'b1) begin nerr++; $display("FAIL fp_dropped: got empty=%0b want 1", fifo_empty); end
    step(0, 0, 32'h0, 32'h0, 1, 1, 0);
    nvec++; if (s_flush !== 1'b0) begin nerr++; $display("FAIL fp_no_flush: got %0b want 0", s_flush); end
    nvec++; if (err_underflow !== 1'b1) begin nerr++; $display("FAIL fp_unf: got %0b want 1", err_underflow); end
    nvec++; if (upd_valid !== 1'b0) begin nerr++; $display("FAIL fp_no_upd: got %0b want 0", upd_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    step(1, 1, 32'h100, 32'h08, 0, 0, 0);
    step(1, 0, 32'h900, 32'h904, 1, 0, 1);
    nvec++; if (s_flush !== 1'b0 || s_redirect !== 32'h0) begin nerr++; $display("FAIL st_hold: got f=%0b pc=%h want f=0 pc=0", s_flush, s_redirect); end
    nvec++; if (upd_valid !== 1'b0 || fifo_empty !== 1'b0) begin nerr++; $display("FAIL st_state: got upd=%0b empty=%0b want 0 0", upd_valid, fifo_empty); end
    step(0, 0, 32'h0, 32'h0, 1, 0, 0);
    nvec++; if (s_flush !== 1'b1 || s_redirect !== 32'h08) begin nerr++; $display("FAIL st_release: got f=%0b pc=%h want f=1 pc=00000008", s_flush, s_redirect); end
    nvec++; if (upd_valid !== 1'b1) begin nerr++; $display("FAIL st_upd: got %0b want 1", upd_valid); end
  endtask

  task automatic test_random();
    bit pv, pt, rv, rt, st;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        pv = ($urandom_range(0, 9) < 6);
        pt = $urandom_range(0, 1);
        rv = ($urandom_range(0, 9) < 4);
        st = ($urandom_range(0, 9) == 0);
        rt = (m_q.size() > 0 && $urandom_range(0, 4) != 0) ? m_q[0].taken : 1'($urandom_range(0, 1));
        step(pv, pt, $urandom, $urandom, rv, rt, st);
        nvec++; if (s_flush !== e_flush) begin nerr++; $display("FAIL rnd_flush r%0d c%0d: got %0b want %0b", r, i, s_flush, e_flush); end
        nvec++; if (s_redirect !== e_redirect) begin nerr++; $display("FAIL rnd_redirect r%0d c%0d: got %h want %h", r, i, s_redirect, e_redirect); end
        nvec++; if (upd_valid !== m_upd_valid || upd_taken !== m_upd_taken) begin nerr++; $display("FAIL rnd_upd r%0d c%0d: got v=%0b t=%0b want v=%0b t=%0b", r, i, upd_valid, upd_taken, m_upd_valid, m_upd_taken); end
        nvec++; if (fifo_full !== (m_q.size() == DEPTH) || fifo_empty !== (m_q.size() == 0)) begin nerr++; $display("FAIL rnd_occ r%0d c%0d: got full=%0b empty=%0b want size=%0d", r, i, fifo_full, fifo_empty, m_q.size()); end
        nvec++; if (err_overflow !== m_ovf || err_underflow !== m_unf) begin nerr++; $display("FAIL rnd_err r%0d c%0d: got ovf=%0b unf=%0b want ovf=%0b unf=%0b", r, i, err_overflow, err_underflow, m_ovf, m_unf); end
`ifdef BRU_PERF_CNT_EN
        nvec++; if (cnt_branch !== CNT_W'(m_cnt_br) || cnt_mispredict !== CNT_W'(m_cnt_mp)) begin nerr++; $display("FAIL rnd_cnt r%0d c%0d: got br=%0d mp=%0d want br=%0d mp=%0d", r, i, cnt_branch, cnt_mispredict, m_cnt_br, m_cnt_mp); end
`endif
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    model_clear();
    test_reset();
    test_correct_predict();
    test_mispredict();
    test_overflow();
    test_full_push_pop();
    test_flush_push();
    test_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
